// File: rtl/tx_frame_sched_pkg.sv
// tx_frame_sched_pkg
// Shared definitions for the LVDS frame scheduler: channel count, frame
// width, FSM state encodings and the width of the partial-frame timeout
// counter (the counter exists only in TX_TIMEOUT_EN builds).
package tx_frame_sched_pkg;

  localparam int CH_NUM   = 2;
  localparam int FRAME_W  = CH_NUM * 8;
  localparam int TO_CNT_W = 16;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2
  } state_e;

endpackage

// File: rtl/tx_frame_sched_ch_slot.sv
// tx_frame_sched_ch_slot (channel slot, tx_ch_slot)
// One frame slot: a byte register plus its filled flag.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   valid_i      source byte valid
//   hold_i       block acceptance (scheduler is launching)
//   pad_i        flush request: fill the slot with pad_byte_i if empty
//   clear_i      frame handed off, slot becomes free
//   data_i       source byte
//   pad_byte_i   filler byte for flushes
//   ready_o      slot can take a byte this cycle
//   filled_o     slot holds a byte
//   byte_o       stored byte
module tx_frame_sched_ch_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic       hold_i,
  input  logic       pad_i,
  input  logic       clear_i,
  input  logic [7:0] data_i,
  input  logic [7:0] pad_byte_i,
  output logic       ready_o,
  output logic       filled_o,
  output logic [7:0] byte_o
);

  logic       filled_q;
  logic [7:0] byte_q;
  logic       accept;

  assign ready_o  = ~filled_q & ~hold_i;
  assign accept   = valid_i & ready_o;
  assign filled_o = filled_q;
  assign byte_o   = byte_q;

  // A real byte arriving on the flush edge wins over the pad byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filled_q <= 1'b0;
      byte_q   <= 8'h00;
    end else if (clear_i) begin
      filled_q <= 1'b0;
    end else if (accept) begin
      filled_q <= 1'b1;
      byte_q   <= data_i;
    end else if (pad_i && !filled_q) begin
      filled_q <= 1'b1;
      byte_q   <= pad_byte_i;
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// tx_frame_sched
// Collects one byte per channel into a frame and launches it to the LVDS
// serializer with a one-cycle tx_ena strobe, gated on tx_busy.
// Optional feature macro: TX_TIMEOUT_EN -- flush a partial frame padded
// with PAD_BYTE after TIMEOUT cycles; without it flush_pulse is tied 0.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   ch_data       channel bytes, channel i on [8i+7:8i]
//   ch_valid      per-channel valid
//   ch_ready      per-channel slot free
//   tx_data       frame to serializer, slot i on [8i+7:8i]
//   tx_ena        one-cycle launch strobe
//   tx_busy       serializer busy
//   frame_cnt     frames launched (wraps)
//   flush_pulse   launched frame was padded
//
// state     | meaning
// S_COLLECT | filling slots, launch when full and serializer idle
// S_LAUNCH  | tx_ena high, serializer captures tx_data at closing edge
// S_WAIT    | next frame may fill, wait for serializer to go idle
module tx_frame_sched
  import tx_frame_sched_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] PAD_BYTE = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] ch_data,
  input  logic [CH_NUM-1:0]  ch_valid,
  output logic [CH_NUM-1:0]  ch_ready,
  output logic [FRAME_W-1:0] tx_data,
  output logic               tx_ena,
  input  logic               tx_busy,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               flush_pulse
);

  // Elaboration-time parameter sanity check.
  if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_CNT_W)) begin : g_bad_timeout
    $error("tx_frame_sched: TIMEOUT out of range");
  end

  state_e             state_q, state_d;
  logic [CH_NUM-1:0]  filled;
  logic [CNT_W-1:0]   cnt_q;
  logic               launch;
  logic               all_full;
  logic               flush_go;

  assign launch   = (state_q == S_LAUNCH);
  assign all_full = &filled;
  assign tx_ena   = launch;
  assign frame_cnt = cnt_q;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_slot
    tx_frame_sched_ch_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (ch_valid[i]),
      .hold_i     (launch),
      .pad_i      (flush_go),
      .clear_i    (launch),
      .data_i     (ch_data[8*i +: 8]),
      .pad_byte_i (PAD_BYTE),
      .ready_o    (ch_ready[i]),
      .filled_o   (filled[i]),
      .byte_o     (tx_data[8*i +: 8])
    );
  end

`ifdef TX_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LIM = TO_CNT_W'(TIMEOUT);

  logic [TO_CNT_W-1:0] to_q, to_d;
  logic                partial;
  logic                flush_q;

  assign partial  = (state_q == S_COLLECT) && (|filled) && !all_full;
  assign flush_go = partial && (to_q >= TO_LIM) && !tx_busy;

  // Saturates at the limit so a busy serializer cannot wrap it past TIMEOUT.
  always_comb begin
    to_d = '0;
    if (partial) begin
      to_d = (to_q >= TO_LIM) ? to_q : to_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q    <= '0;
      flush_q <= 1'b0;
    end else begin
      to_q    <= to_d;
      flush_q <= flush_go;
    end
  end

  assign flush_pulse = flush_q;
`else
  assign flush_go    = 1'b0;
  assign flush_pulse = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: begin
        if ((all_full && !tx_busy) || flush_go) state_d = S_LAUNCH;
      end
      S_LAUNCH:  state_d = S_WAIT;
      S_WAIT: begin
        if (!tx_busy) state_d = S_COLLECT;
      end
      default:   state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (launch) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
